// File: rtl/lfsr_seed_sequencer.sv
// lfsr_seed_sequencer
//  Steps a SEED_WIDTH-bit LFSR (fb = s[W-1]^s[3]^s[2]^s[0], shift left) and
//  hands out one registered seed per frame over a valid/ready handshake,
//  together with the seed's index within the run.
//  Optional build macro: LFSR_SEQ_PERIOD_CHECK_EN adds output period_err,
//  which pulses on the transfer of a seed equal to the run's first seed.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | waiting for load (reseed) or start (begin a run)
//  STEP    | advancing the LFSR, one step per cycle, STEPS_PER_SEED steps
//  PRESENT | seed_valid high, holding seed/count until seed_ready
module lfsr_seed_sequencer #(
    parameter int                    SEED_WIDTH     = 70,
    parameter int                    COUNTERSIZE    = 4,
    parameter int                    STEPS_PER_SEED = 10,
    parameter logic [SEED_WIDTH-1:0] LOCKUP_SEED    = 'h1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [SEED_WIDTH-1:0]  load_seed,
    input  logic                   start,
    input  logic [COUNTERSIZE-1:0] frames,
    input  logic                   seed_ready,
    output logic                   seed_valid,
    output logic [SEED_WIDTH-1:0]  seed,
    output logic [COUNTERSIZE-1:0] count,
    output logic                   busy,
    output logic                   lockup_err
`ifdef LFSR_SEQ_PERIOD_CHECK_EN
    ,
    output logic                   period_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STEP    = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    // Down-counter reload: terminal count 0 marks the last step of a seed.
    localparam logic [7:0]             STEP_LAST = 8'(STEPS_PER_SEED - 1);
    localparam logic [COUNTERSIZE-1:0] CNT_ONE   = COUNTERSIZE'(1);

    function automatic logic [SEED_WIDTH-1:0] lfsr_step(input logic [SEED_WIDTH-1:0] s);
        logic fb;
        fb = s[SEED_WIDTH-1] ^ s[3] ^ s[2] ^ s[0];
        return {s[SEED_WIDTH-2:0], fb};
    endfunction

    state_t                 state_q, state_d;
    logic [SEED_WIDTH-1:0]  lfsr_q, lfsr_d;
    logic [SEED_WIDTH-1:0]  seed_q, seed_d;
    logic [COUNTERSIZE-1:0] count_q, count_d;
    logic [COUNTERSIZE-1:0] frames_q, frames_d;
    logic [7:0]             step_q, step_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;

    logic [SEED_WIDTH-1:0]  lfsr_raw;
    logic                   raw_zero;
    logic [SEED_WIDTH-1:0]  lfsr_nxt;
    logic                   xfer;
    logic                   last_seed;

    // Next LFSR value with all-zero lockup replaced by LOCKUP_SEED.
    always_comb begin
        lfsr_raw = lfsr_step(lfsr_q);
        raw_zero = (lfsr_raw == '0);
        lfsr_nxt = raw_zero ? LOCKUP_SEED : lfsr_raw;
    end

    assign xfer      = valid_q && seed_ready;
    // frames==0 wraps to all-ones here, so a zero request gives 2**COUNTERSIZE seeds.
    assign last_seed = (count_q == (frames_q - CNT_ONE));

    // Next-state and datapath updates for the sequencer FSM.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        seed_d   = seed_q;
        count_d  = count_q;
        frames_d = frames_q;
        step_d   = step_q;
        valid_d  = valid_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    if (load_seed == '0) begin
                        lfsr_d = LOCKUP_SEED;
                        err_d  = 1'b1;
                    end else begin
                        lfsr_d = load_seed;
                        err_d  = 1'b0;
                    end
                end else if (start) begin
                    frames_d = frames;
                    count_d  = '0;
                    step_d   = STEP_LAST;
                    state_d  = S_STEP;
                end
            end
            S_STEP: begin
                lfsr_d = lfsr_nxt;
                if (raw_zero) begin
                    err_d = 1'b1;
                end
                if (step_q == 8'd0) begin
                    seed_d  = lfsr_nxt;
                    valid_d = 1'b1;
                    state_d = S_PRESENT;
                end else begin
                    step_d = step_q - 8'd1;
                end
            end
            S_PRESENT: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    if (last_seed) begin
                        state_d = S_IDLE;
                    end else begin
                        count_d = count_q + CNT_ONE;
                        step_d  = STEP_LAST;
                        state_d = S_STEP;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            lfsr_q   <= LOCKUP_SEED;
            seed_q   <= '0;
            count_q  <= '0;
            frames_q <= '0;
            step_q   <= 8'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            seed_q   <= seed_d;
            count_q  <= count_d;
            frames_q <= frames_d;
            step_q   <= step_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign seed_valid = valid_q;
    assign seed       = seed_q;
    assign count      = count_q;
    assign busy       = (state_q != S_IDLE);
    assign lockup_err = err_q;

`ifdef LFSR_SEQ_PERIOD_CHECK_EN
    logic [SEED_WIDTH-1:0] first_q, first_d;

    // Capture the first seed of each run as it is emitted.
    always_comb begin
        first_d = first_q;
        if (state_q == S_STEP && step_q == 8'd0 && count_q == '0) begin
            first_d = lfsr_nxt;
        end
    end

    // First-seed store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q <= '0;
        end else begin
            first_q <= first_d;
        end
    end

    assign period_err = (state_q == S_PRESENT) && xfer && (count_q != '0) && (seed_q == first_q);
`endif

endmodule
